// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle main controller.
// Optional feature macro: MC_CTRL_JR_EN (enables the jr state).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_MEM_WB,
        S_IMM_EX,
        S_IMM_WB,
        S_EXEC_R,
        S_R_WB,
        S_BRANCH,
        S_JUMP,
        S_JR,
        S_TRAP
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b0011;
    localparam logic [3:0] OP_SLTI  = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0101;
    localparam logic [3:0] OP_J     = 4'b0110;

    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_SLT   = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b11;

    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b0001;
    localparam logic [3:0] FUNCT_AND = 4'b0010;
    localparam logic [3:0] FUNCT_OR  = 4'b0011;
    localparam logic [3:0] FUNCT_SLT = 4'b0100;
    localparam logic [3:0] FUNCT_JR  = 4'b1000;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    // Complete datapath control word produced for one state.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [3:0] alu_funct;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control word decode for the main controller.
// Optional feature macro: MC_CTRL_JR_EN (decodes the jr state).
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       imm_slt,
    input  logic [3:0] funct,
    output ctrl_t      ctrl
);

    // Moore decode; only the fetch load enables look at mem_ready.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BROFF;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_IMM_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = imm_slt ? ALUOP_SLT : ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_IMM_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_RTYPE;
                ctrl.alu_funct = funct;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MC_CTRL_JR_EN
            S_JR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_RS;
            end
`endif
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle main control FSM: state register, next-state logic and
// retired-instruction counter; the control word comes from mc_ctrl_outdec.
// Optional feature macro: MC_CTRL_JR_EN (R-type funct 1000 becomes jr).
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic [3:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       alu_funct,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_cnt
);

    state_t state, state_nxt;
    logic   is_sw, is_sw_nxt;
    logic   imm_slt, imm_slt_nxt;
    logic   retire;
    ctrl_t  ctrl;

    // The branch decision (pc_write_cond & zero) is made in the datapath;
    // the controller never needs the flag itself.
    logic   unused_zero;
    assign unused_zero = zero;

    // State register plus the decode-time flags that later states rely on,
    // because the opcode is not guaranteed stable after DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            is_sw   <= 1'b0;
            imm_slt <= 1'b0;
        end else begin
            state   <= state_nxt;
            is_sw   <= is_sw_nxt;
            imm_slt <= imm_slt_nxt;
        end
    end

    // Next-state logic; opcode is looked at only in DECODE.
    always_comb begin
        state_nxt   = state;
        is_sw_nxt   = is_sw;
        imm_slt_nxt = imm_slt;
        case (state)
            S_FETCH: if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                is_sw_nxt   = (opcode == OP_SW);
                imm_slt_nxt = (opcode == OP_SLTI);
                case (opcode)
                    OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
                    OP_ADDI, OP_SLTI: state_nxt = S_IMM_EX;
`ifdef MC_CTRL_JR_EN
                    OP_RTYPE:         state_nxt = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
`else
                    OP_RTYPE:         state_nxt = S_EXEC_R;
`endif
                    OP_BEQ:           state_nxt = S_BRANCH;
                    OP_J:             state_nxt = S_JUMP;
                    default:          state_nxt = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_nxt = is_sw ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
            S_IMM_EX:   state_nxt = S_IMM_WB;
            S_EXEC_R:   state_nxt = S_R_WB;
            S_MEM_WB, S_IMM_WB, S_R_WB,
            S_BRANCH, S_JUMP, S_JR, S_TRAP: state_nxt = S_FETCH;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Any return to FETCH completes an instruction, except leaving TRAP.
    assign retire = (state != S_FETCH) && (state != S_TRAP) && (state_nxt == S_FETCH);

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_cnt <= '0;
        else if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
    end

    mc_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .imm_slt   (imm_slt),
        .funct     (funct),
        .ctrl      (ctrl)
    );

    assign mem_req       = ctrl.mem_req;
    assign mem_we        = ctrl.mem_we;
    assign i_or_d        = ctrl.i_or_d;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign alu_funct     = ctrl.alu_funct;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign illegal_op    = ctrl.illegal_op;

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: directed vector table, a
// reset/wrap sequence and a randomized run against a timeline model.
module tb_mc_main_control;

    localparam int CW = 8;

`ifdef MC_CTRL_JR_EN
    localparam bit JR_EN = 1'b1;
`else
    localparam bit JR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    opcode, funct;
    logic          zero, mem_ready;
    logic          mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0]    pc_source, alu_src_b, alu_op;
    logic          alu_src_a;
    logic [3:0]    alu_funct;
    logic          reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [CW-1:0] retired_cnt;

    always #5 clk = ~clk;

    mc_main_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .alu_funct(alu_funct), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
        .retired_cnt(retired_cnt)
    );

    typedef struct packed {
        logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [3:0] alu_funct;
        logic       reg_write, reg_dst, mem_to_reg, illegal_op;
    } cw_t;

    cw_t act;
    assign act = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                  alu_src_a, alu_src_b, alu_op, alu_funct, reg_write, reg_dst,
                  mem_to_reg, illegal_op};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- timeline reference model ----------------
    typedef struct packed {
        logic [3:0]    op;
        logic [3:0]    fn;
        logic          mr;
        cw_t           exp;
        logic [CW-1:0] cnt;
    } cyc_t;

    cyc_t          q[$];
    logic [CW-1:0] m_cnt;

    task automatic push(input logic [3:0] op, input logic [3:0] fn, input logic mr, input cw_t w);
        cyc_t c;
        c.op = op; c.fn = fn; c.mr = mr; c.exp = w; c.cnt = m_cnt;
        q.push_back(c);
    endtask

    // Cycle where opcode/funct must not matter: drive junk.
    task automatic push_g(input logic mr, input cw_t w);
        push(4'($urandom), 4'($urandom), mr, w);
    endtask

    task automatic model_instr(input logic [3:0] op, input logic [3:0] fn, input int fw, input int mw);
        cw_t w;
        bit  ret;
        for (int i = 0; i <= fw; i++) begin
            w = '0; w.mem_req = 1'b1; w.alu_src_b = 2'b01; w.alu_op = 2'b11;
            w.ir_write = (i == fw); w.pc_write = (i == fw);
            push_g(i == fw, w);
        end
        w = '0; w.alu_src_b = 2'b11; w.alu_op = 2'b11;
        push(op, fn, 1'($urandom), w);
        ret = 1'b1;
        if (op == 4'd0 && fn == 4'b1000 && JR_EN) begin
            w = '0; w.pc_write = 1'b1; w.pc_source = 2'b11;
            push_g(1'($urandom), w);
        end else if (op == 4'd0) begin
            w = '0; w.alu_src_a = 1'b1; w.alu_op = 2'b00; w.alu_funct = fn;
            push(4'($urandom), fn, 1'($urandom), w);
            w = '0; w.reg_write = 1'b1; w.reg_dst = 1'b1;
            push_g(1'($urandom), w);
        end else if (op == 4'd1 || op == 4'd2) begin
            w = '0; w.alu_src_a = 1'b1; w.alu_src_b = 2'b10; w.alu_op = 2'b11;
            push_g(1'($urandom), w);
            for (int i = 0; i <= mw; i++) begin
                w = '0; w.mem_req = 1'b1; w.i_or_d = 1'b1; w.mem_we = (op == 4'd2);
                push_g(i == mw, w);
            end
            if (op == 4'd1) begin
                w = '0; w.reg_write = 1'b1; w.mem_to_reg = 1'b1;
                push_g(1'($urandom), w);
            end
        end else if (op == 4'd3 || op == 4'd4) begin
            w = '0; w.alu_src_a = 1'b1; w.alu_src_b = 2'b10;
            w.alu_op = (op == 4'd4) ? 2'b10 : 2'b11;
            push_g(1'($urandom), w);
            w = '0; w.reg_write = 1'b1;
            push_g(1'($urandom), w);
        end else if (op == 4'd5) begin
            w = '0; w.alu_src_a = 1'b1; w.alu_op = 2'b01; w.pc_write_cond = 1'b1; w.pc_source = 2'b01;
            push_g(1'($urandom), w);
        end else if (op == 4'd6) begin
            w = '0; w.pc_write = 1'b1; w.pc_source = 2'b10;
            push_g(1'($urandom), w);
        end else begin
            w = '0; w.illegal_op = 1'b1;
            push_g(1'($urandom), w);
            ret = 1'b0;
        end
        if (ret) m_cnt = m_cnt + 1'b1;
    endtask

    // ---------------- reactive runner for the vector table ----------------
    // Called at a negedge with the DUT in its first FETCH cycle; returns at
    // the negedge where the following FETCH begins.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input int fw, input int mw,
                             input logic z, output int cyc, output int n_ill, output int n_rw,
                             output int n_jr, output int n_pcld, output bit to);
        int fc = 0;
        int mc = 0;
        bit left = 1'b0;
        bit done = 1'b0;
        int k = 0;
        cyc = 0; n_ill = 0; n_rw = 0; n_jr = 0; n_pcld = 0; to = 1'b1;
        while (!done && k < 40) begin
            if (mem_req && !i_or_d && left) begin
                done = 1'b1;
                to   = 1'b0;
            end else begin
                opcode = op; funct = fn; zero = z;
                if (mem_req && !i_or_d) begin
                    mem_ready = (fc == fw); fc++;
                end else if (mem_req && i_or_d) begin
                    mem_ready = (mc == mw); mc++; left = 1'b1;
                end else begin
                    mem_ready = 1'b0; left = 1'b1;
                end
                #1;
                if (illegal_op) n_ill++;
                if (reg_write) n_rw++;
                if (pc_write && pc_source == 2'b11) n_jr++;
                if (pc_write || (pc_write_cond && z)) n_pcld++;
                cyc++;
                k++;
                @(negedge clk);
            end
        end
    endtask

    typedef struct {
        logic [3:0] op, fn;
        int fw, mw;
        logic z;
        int lat, ret, ill, rw, jr, pcld;
    } vec_t;

    vec_t tbl[14];

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n_ill, n_rw, n_jr, n_pcld;
        bit to;
        logic [CW-1:0] c0;
        cw_t fw0;
        cyc_t c;

        //           op     fn    fw mw z   lat ret ill rw jr pcld
        tbl[0]  = '{4'h0, 4'h1, 0, 0, 1'b0, 4, 1, 0, 1, 0, 1};
        tbl[1]  = '{4'h1, 4'h0, 0, 3, 1'b0, 8, 1, 0, 1, 0, 1};
        tbl[2]  = '{4'h5, 4'h0, 0, 0, 1'b1, 3, 1, 0, 0, 0, 2};
        tbl[3]  = '{4'h5, 4'h0, 0, 0, 1'b0, 3, 1, 0, 0, 0, 1};
        tbl[4]  = '{4'hF, 4'h0, 0, 0, 1'b0, 3, 0, 1, 0, 0, 1};
`ifdef MC_CTRL_JR_EN
        tbl[5]  = '{4'h0, 4'h8, 0, 0, 1'b0, 3, 1, 0, 0, 1, 2};
`else
        tbl[5]  = '{4'h0, 4'h8, 0, 0, 1'b0, 4, 1, 0, 1, 0, 1};
`endif
        tbl[6]  = '{4'h2, 4'h0, 0, 0, 1'b0, 4, 1, 0, 0, 0, 1};
        tbl[7]  = '{4'h2, 4'h0, 0, 2, 1'b0, 6, 1, 0, 0, 0, 1};
        tbl[8]  = '{4'h3, 4'h0, 2, 0, 1'b0, 6, 1, 0, 1, 0, 1};
        tbl[9]  = '{4'h4, 4'h0, 0, 0, 1'b0, 4, 1, 0, 1, 0, 1};
        tbl[10] = '{4'h6, 4'h0, 0, 0, 1'b0, 3, 1, 0, 0, 0, 2};
        tbl[11] = '{4'h1, 4'h0, 1, 0, 1'b0, 6, 1, 0, 1, 0, 1};
        tbl[12] = '{4'h7, 4'h0, 0, 0, 1'b0, 3, 0, 1, 0, 0, 1};
        tbl[13] = '{4'h0, 4'h2, 1, 0, 1'b0, 5, 1, 0, 1, 0, 1};

        opcode = 4'h0; funct = 4'h0; zero = 1'b0; mem_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        // During reset only the FETCH values show (mem_ready low here).
        fw0 = '0; fw0.mem_req = 1'b1; fw0.alu_src_b = 2'b01; fw0.alu_op = 2'b11;
        check("reset_ctl", 32'(act), 32'(fw0));
        check("reset_cnt", 32'(retired_cnt), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            c0 = retired_cnt;
            run_instr(tbl[i].op, tbl[i].fn, tbl[i].fw, tbl[i].mw, tbl[i].z,
                      cyc, n_ill, n_rw, n_jr, n_pcld, to);
            check($sformatf("vec%0d_timeout", i), 32'(to), 32'd0);
            check($sformatf("vec%0d_latency", i), 32'(cyc), 32'(tbl[i].lat));
            check($sformatf("vec%0d_retired", i), 32'(CW'(retired_cnt - c0)), 32'(tbl[i].ret));
            check($sformatf("vec%0d_illegal", i), 32'(n_ill), 32'(tbl[i].ill));
            check($sformatf("vec%0d_regwrite", i), 32'(n_rw), 32'(tbl[i].rw));
            check($sformatf("vec%0d_jr", i), 32'(n_jr), 32'(tbl[i].jr));
            check($sformatf("vec%0d_pcload", i), 32'(n_pcld), 32'(tbl[i].pcld));
        end

        // Randomized stream against the timeline model.
        do_reset();
        m_cnt = '0;
        for (int n = 0; n < 200; n++) begin
            logic [3:0] op, fn;
            int r;
            op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(7, 15));
            r = $urandom_range(0, 7);
            case (r)
                0: fn = 4'h0; 1: fn = 4'h1; 2: fn = 4'h2; 3: fn = 4'h3;
                4: fn = 4'h4; 5: fn = 4'h8; default: fn = 4'($urandom);
            endcase
            model_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        while (q.size() > 0) begin
            c = q.pop_front();
            opcode = c.op; funct = c.fn; mem_ready = c.mr; zero = 1'($urandom);
            #1;
            check("rand_ctl", 32'(act), 32'(c.exp));
            check("rand_cnt", 32'(retired_cnt), 32'(c.cnt));
            @(negedge clk);
        end

        // Reset in MEM_WR: the write request is abandoned immediately.
        opcode = 4'h2; mem_ready = 1'b1;
        @(negedge clk);          // DECODE
        mem_ready = 1'b0;
        @(negedge clk);          // MEM_ADDR
        @(negedge clk);          // MEM_WR, memory stalls
        #1;
        check("memwr_we", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_we", 32'(mem_we), 32'd0);
        check("rst_async_iord", 32'(i_or_d), 32'd0);
        check("rst_async_cnt", 32'(retired_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(4'h0, 4'h0, 0, 0, 1'b0, cyc, n_ill, n_rw, n_jr, n_pcld, to);
        check("restart_latency", 32'(cyc), 32'd4);
        check("restart_cnt", 32'(retired_cnt), 32'd1);

        // Counter wrap with jumps as nops.
        do_reset();
        for (int i = 0; i < 255; i++)
            run_instr(4'h6, 4'h0, 0, 0, 1'b0, cyc, n_ill, n_rw, n_jr, n_pcld, to);
        check("wrap_max", 32'(retired_cnt), 32'hFF);
        run_instr(4'h6, 4'h0, 0, 0, 1'b0, cyc, n_ill, n_rw, n_jr, n_pcld, to);
        check("wrap_zero", 32'(retired_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multi-cycle main control FSM for the 16-bit MIPS-style core. It sequences fetch, decode, execute, memory and write-back. It drives the datapath enables and muxes and produces the `alu_op`/`alu_funct` pair consumed by the ALU control decoder. It also owns the instruction/data memory request handshake and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `opcode`, input, 4: IR[15:12]; valid from DECODE onward.
- `funct`, input, 4: IR[3:0].
- `zero`, input, 1: ALU zero flag.
- `mem_ready`, input, 1: memory completes the current request.
- `mem_req`, output, 1: memory request.
- `mem_we`, output, 1: write request; only ever high together with `mem_req`.
- `i_or_d`, output, 1: address select; 0 = PC, 1 = ALUOut.
- `ir_write`, output, 1: IR load enable.
- `pc_write`, output, 1: unconditional PC load.
- `pc_write_cond`, output, 1: PC load when `zero`.
- `pc_source`, output, 2: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = register rs.
- `alu_src_a`, output, 1: 0 = PC, 1 = A.
- `alu_src_b`, output, 2: 00 = B, 01 = const 1, 10 = sign-ext imm, 11 = sign-ext imm (branch offset).
- `alu_op`, output, 2: 11 = add, 10 = slt, 01 = sub, 00 = R-type (use funct).
- `alu_funct`, output, 4: forwarded funct; 0000 outside R-type states.
- `reg_write`, output, 1: register file write enable.
- `reg_dst`, output, 1: 0 = rt, 1 = rd.
- `mem_to_reg`, output, 1: write-back select.
- `illegal_op`, output, 1: one-cycle pulse on an undefined opcode.
- `retired_cnt`, output, CNT_W: retired-instruction count.

## Operation
Opcodes:
- 0000 R-type; 0001 lw; 0010 sw; 0011 addi; 0100 slti; 0101 beq; 0110 j.
- Every other opcode is illegal.

R-type funct values: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, 1000 jr. Any other funct executes as add; ALU control defaults it that way.

States and transitions:
- FETCH → DECODE when `mem_ready`; otherwise stay.
- DECODE → by opcode:
  - lw, sw, addi, slti → MEM_ADDR/IMM_EX.
  - R-type → EXEC_R, or JR when funct = 1000 (see Configuration).
  - beq → BRANCH; j → JUMP; illegal → TRAP.
- MEM_ADDR → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD → MEM_WB when `mem_ready`.
- MEM_WR → FETCH when `mem_ready`.
- MEM_WB → FETCH.
- IMM_EX → IMM_WB → FETCH.
- EXEC_R → R_WB → FETCH.
- BRANCH, JUMP, JR, TRAP → FETCH.

Moore outputs per state (all unlisted outputs are 0):
- FETCH: `mem_req`, `ir_write` (qualified with `mem_ready`), `alu_src_b`=01, `alu_op`=11, `pc_write` (qualified with `mem_ready`).
- DECODE: `alu_src_b`=11, `alu_op`=11; computes the branch target.
- MEM_ADDR, IMM_EX (addi): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11.
- IMM_EX (slti): same, except `alu_op`=10.
- MEM_RD: `mem_req`, `i_or_d`=1.
- MEM_WR: `mem_req`, `mem_we`, `i_or_d`=1.
- MEM_WB: `reg_write`, `mem_to_reg`=1.
- IMM_WB: `reg_write`.
- EXEC_R: `alu_src_a`=1, `alu_op`=00, `alu_funct`=`funct`.
- R_WB: `reg_write`, `reg_dst`=1.
- BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_write_cond`, `pc_source`=01.
- JUMP: `pc_write`, `pc_source`=10.
- JR: `pc_write`, `pc_source`=11.
- TRAP: `illegal_op`.

`retired_cnt` increments by 1, wrapping modulo 2^CNT_W, on entry to FETCH from any completing state except TRAP.

## Timing
- Reset: state = FETCH, `retired_cnt` = 0. Every output other than the FETCH Moore values reads 0 during reset.
- `mem_req` is asserted continuously in a memory state until the edge on which `mem_ready` = 1; that edge advances the state.
- `mem_ready` outside a memory state is ignored.
- Zero-wait latency, in cycles:
  - R-type 4, lw 5, sw 4, addi/slti 4.
  - beq 3, j 3, jr 3, illegal 3.
- Each wait cycle adds exactly 1.
- Reset asserted mid-instruction aborts immediately. No partial write-back; any pending memory request is dropped.
- `opcode`/`funct` are sampled only in DECODE and EXEC_R. Changes at other times have no effect.

## Configuration
- `MC_CTRL_JR_EN` defined: R-type with funct 1000 goes to JR (PC ← rs, 3 cycles).
- Not defined: funct 1000 executes as R-type add through EXEC_R/R_WB. The JR state and `pc_source`=11 are never produced.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - opcode constants;
  - `alu_op` constants (ALUOP_RTYPE/SUB/SLT/ADD);
  - funct constants including FUNCT_JR;
  - `pc_source`/`alu_src_b` encodings.
- One sub-module, `mc_ctrl_outdec`: purely combinational state → control-word decode. The FSM register, next-state logic and counter stay in the top.

## Test plan
- Reset, then release with `mem_ready`=1 and opcode 0000/funct 0001: states FETCH, DECODE, EXEC_R, R_WB. In EXEC_R, `alu_op`=00 and `alu_funct`=0001. `retired_cnt`=1 after 4 cycles.
- lw with `mem_ready` low for 3 cycles in MEM_RD: `mem_req`=`i_or_d`=1 is held for 4 cycles. Total latency is 8. `reg_write`+`mem_to_reg` is high for exactly 1 cycle.
- beq with `zero`=1 then `zero`=0: `alu_op`=01 and `pc_write_cond`=1 in BRANCH both times; the PC load follows `zero`. Each takes 3 cycles.
- Opcode 1111: `illegal_op` pulses once, the FSM returns to FETCH, and `retired_cnt` is unchanged.
- funct 1000 with and without `MC_CTRL_JR_EN`: `pc_source`=11 with `pc_write` in 3 cycles when defined; an add through R_WB when not defined.
- Set `retired_cnt` to 0xFFFF via 65535 nops; the next retire wraps it to 0. Asserting `rst_n` low in MEM_WR drops `mem_req` asynchronously, and the FSM restarts in FETCH.
